// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : Shared widths and helpers for the fir_filter output path.
// Revision : 1.0
// ============================================================================
package fir_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 8;

    typedef struct packed {
        logic        sat;
        logic [31:0] value;
    } round_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Round half up, shift right, clip to out_w bits; one spare bit keeps the add from wrapping.
    function automatic round_t sat_round(input logic [31:0] x, input int shift, input int out_w);
        round_t      res;
        logic [32:0] sum;
        logic [32:0] r;
        logic [32:0] maxv;
        sum       = {1'b0, x} + (33'd1 << (shift - 1));
        r         = sum >> shift;
        maxv      = (33'd1 << out_w) - 33'd1;
        res.sat   = (r > maxv);
        res.value = res.sat ? maxv[31:0] : r[31:0];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_fifo
// Brief    : Show-ahead synchronous FIFO with a registered head word.
// Revision : 1.0
// ============================================================================
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [W-1:0]          i_data,
    input  logic                  i_pop,
    output logic [W-1:0]          o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [clog2(DEPTH):0] o_level
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_LW-1:0] r_level;
    logic [W-1:0]    r_head;

    logic            w_pop;
    logic            w_push;
    logic [c_AW-1:0] w_rptr_nxt;
    logic [c_LW-1:0] w_remain;

    assign o_full     = (r_level == c_LW'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign w_pop      = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push     = i_push & (~o_full | w_pop);
    assign w_rptr_nxt = r_rptr + c_AW'(w_pop);
    assign w_remain   = r_level - c_LW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            r_rptr <= w_rptr_nxt;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
            // Head follows the next unread entry; it holds its value once the FIFO drains.
            if (w_remain == '0) begin
                if (w_push) begin
                    r_head <= i_data;
                end
            end else begin
                r_head <= r_mem[w_rptr_nxt];
            end
        end
    end

    assign o_data  = r_head;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/fir_out_decimator.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_decimator
// Brief    : Decimate, requantise and buffer the fir_filter output stream.
// Revision : 1.0
// ============================================================================
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 4,
    parameter int DECIM = 2,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_data,
    input  logic                  out_ready,
    output logic                  sat,
    output logic                  ovf,
    output logic [7:0]            drop_cnt,
    output logic [clog2(DEPTH):0] level,
    input  logic                  ovf_clr
);

    localparam int c_PH_W = (DECIM > 1) ? clog2(DECIM) : 1;

    logic [c_PH_W-1:0] r_phase;
    logic              r_s1_valid;
    logic [OUT_W-1:0]  r_s1_data;
    logic              r_sat;
    logic              r_ovf;
    logic [7:0]        r_drop_cnt;

    round_t            w_rq;
    logic              w_keep;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_drop;

    assign w_keep = in_valid & (r_phase == '0);
    assign w_rq   = sat_round(32'(in_data), SHIFT, OUT_W);

    generate
        if (OUT_W < 32) begin : g_trim
            logic w_unused_hi;
            assign w_unused_hi = ^w_rq.value[31:OUT_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (in_valid) begin
            if (r_phase == c_PH_W'(DECIM - 1)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + c_PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
            r_s1_data  <= w_rq.value[OUT_W-1:0];
            r_sat      <= w_keep & w_rq.sat;
        end
    end

    fir_out_fifo #(
        .DEPTH (DEPTH),
        .W     (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_s1_valid),
        .i_data  (r_s1_data),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_drop    = r_s1_valid & w_full & ~w_pop;

    // A drop in the same cycle as a clear takes priority so no loss goes unreported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign sat      = r_sat;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
